// File: rtl/motor_stop_pkg.sv
// Shared types and constants for the motor stop sequencer.
package motor_stop_pkg;

  localparam int THR_W   = 11;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_RAMPDOWN = 3'd3,
    ST_STOPPED  = 3'd4
  } state_t;

  // Throttle minus step, clamped at zero. The extra top bit of the
  // difference is the borrow, which means the step overshot zero.
  function automatic logic [THR_W-1:0] thr_sat_sub(
    input logic [THR_W-1:0] a,
    input logic [THR_W:0]   b
  );
    logic [THR_W:0] diff;
    diff = {1'b0, a} - b;
    return diff[THR_W] ? '0 : diff[THR_W-1:0];
  endfunction

endpackage

// File: rtl/stop_wdt.sv
// Heartbeat watchdog: counts while enabled, restarts on kick, and flags
// expiry in the cycle where the count sits at WDT_CYCLES-1 with no kick.
module stop_wdt #(
  parameter int WDT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count up while enabled; disable or kick restarts from zero, and the
  // count parks at its last value until the owner leaves the enabled state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!enable || kick) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A kick in the expiry cycle wins, so there is no expiry then.
  assign expired = enable && !kick && (r_cnt == CNT_LAST);

endmodule

// File: rtl/motor_stop_seq.sv
// Motor arm / soft-stop sequencer with throttle ramp-down.
// Optional heartbeat watchdog compiled in with `define MOTOR_STOP_WDT_EN;
// without it heartbeat is ignored and fault_wdt stays 0.
module motor_stop_seq
  import motor_stop_pkg::*;
#(
  parameter int ARM_HOLD   = 25000000,
  parameter int RAMP_DIV   = 50000,
  parameter int RAMP_STEP  = 8,
  parameter int WDT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm_req,
  input  logic               stop_req,
  input  logic               heartbeat,
  input  logic               clear_req,
  input  logic [THR_W-1:0]   throttle_in,
  output logic [THR_W-1:0]   throttle_out,
  output logic               stop,
  output logic [STATE_W-1:0] state,
  output logic               fault_wdt
);

  localparam int HOLD_W = $clog2(ARM_HOLD + 1);
  localparam int DIV_W  = $clog2(RAMP_DIV + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ARM_HOLD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  // A step larger than full scale behaves the same as full scale.
  localparam int STEP_CLAMP = (RAMP_STEP > (1 << THR_W)) ? (1 << THR_W) : RAMP_STEP;
  localparam logic [THR_W:0] STEP_EXT = (THR_W + 1)'(STEP_CLAMP);

  state_t             r_state;
  logic [THR_W-1:0]   r_thr;
  logic               r_stop;
  logic               r_fault;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [DIV_W-1:0]   r_div_cnt;

  state_t             w_next_state;
  logic [THR_W-1:0]   w_thr_next;
  logic               w_stop_next;
  logic               w_fault_next;
  logic [HOLD_W-1:0]  w_hold_next;
  logic [DIV_W-1:0]   w_div_next;
  logic               w_expired;

`ifdef MOTOR_STOP_WDT_EN
  stop_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (r_state == ST_ARMED),
    .kick    (heartbeat),
    .expired (w_expired)
  );
`else
  logic w_unused;
  assign w_unused  = heartbeat ^ (WDT_CYCLES == 0);
  assign w_expired = 1'b0;
`endif

  // Next-state, next-output and counter logic; outputs are derived from the
  // state being entered so that every output comes straight from a register.
  always_comb begin
    w_next_state = r_state;
    w_thr_next   = '0;
    w_fault_next = r_fault;
    w_hold_next  = '0;
    w_div_next   = '0;
    case (r_state)
      ST_DISARMED: begin
        if (arm_req && !stop_req && (throttle_in == '0)) begin
          w_next_state = ST_ARMING;
        end
      end
      ST_ARMING: begin
        if (!arm_req || stop_req) begin
          w_next_state = ST_DISARMED;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_next_state = ST_ARMED;
          w_thr_next   = throttle_in;
        end else begin
          w_hold_next = r_hold_cnt + 1'b1;
        end
      end
      ST_ARMED: begin
        // All exit causes share one entry into the ramp, starting from the
        // throttle currently delivered.
        if (stop_req || !arm_req || w_expired) begin
          w_next_state = ST_RAMPDOWN;
          w_thr_next   = r_thr;
          if (w_expired) begin
            w_fault_next = 1'b1;
          end
        end else begin
          w_thr_next = throttle_in;
        end
      end
      ST_RAMPDOWN: begin
        if (r_thr == '0) begin
          w_next_state = ST_STOPPED;
        end else if (r_div_cnt == DIV_LAST) begin
          w_thr_next = thr_sat_sub(r_thr, STEP_EXT);
        end else begin
          w_thr_next = r_thr;
          w_div_next = r_div_cnt + 1'b1;
        end
      end
      ST_STOPPED: begin
        if (clear_req && !stop_req && !arm_req) begin
          w_next_state = ST_DISARMED;
          w_fault_next = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_STOPPED;
      end
    endcase
    w_stop_next = !((w_next_state == ST_ARMED) || (w_next_state == ST_RAMPDOWN));
  end

  // State, output and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_DISARMED;
      r_thr      <= '0;
      r_stop     <= 1'b1;
      r_fault    <= 1'b0;
      r_hold_cnt <= '0;
      r_div_cnt  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_thr      <= w_thr_next;
      r_stop     <= w_stop_next;
      r_fault    <= w_fault_next;
      r_hold_cnt <= w_hold_next;
      r_div_cnt  <= w_div_next;
    end
  end

  assign throttle_out = r_thr;
  assign stop         = r_stop;
  assign state        = r_state;
  assign fault_wdt    = r_fault;

endmodule

// File: tb/tb_motor_stop_seq.sv
// Scoreboard bench for motor_stop_seq: stimulus queues expected snapshots
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_motor_stop_seq;

  logic        clk;
  logic        reset_n;
  logic        arm_req;
  logic        stop_req;
  logic        heartbeat;
  logic        clear_req;
  logic [10:0] throttle_in;
  logic [10:0] throttle_out;
  logic        stop;
  logic [2:0]  state;
  logic        fault_wdt;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    int          due;
    logic [2:0]  st;
    logic        stp;
    logic [10:0] thr;
    logic        flt;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  motor_stop_seq #(
    .ARM_HOLD   (4),
    .RAMP_DIV   (2),
    .RAMP_STEP  (100),
    .WDT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm_req      (arm_req),
    .stop_req     (stop_req),
    .heartbeat    (heartbeat),
    .clear_req    (clear_req),
    .throttle_in  (throttle_in),
    .throttle_out (throttle_out),
    .stop         (stop),
    .state        (state),
    .fault_wdt    (fault_wdt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued snapshot at the negedge of its due cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    string       nm;
    logic [15:0] got;
    logic [15:0] want;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e    = sb.pop_front();
      nm   = sb_name.pop_front();
      got  = {state, stop, throttle_out, fault_wdt};
      want = {e.st, e.stp, e.thr, e.flt};
      n_checks++;
      if (e.due != cyc) begin
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", nm, cyc, e.due);
      end else if (got !== want) begin
        $display("FAIL %s: got state=%0d stop=%0b thr=%0d fault=%0b, want state=%0d stop=%0b thr=%0d fault=%0b",
                 nm, state, stop, throttle_out, fault_wdt, e.st, e.stp, e.thr, e.flt);
      end else begin
        n_pass++;
        $display("ok   %s: state=%0d stop=%0b thr=%0d fault=%0b", nm, state, stop, throttle_out, fault_wdt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected snapshot d clock edges from now.
  task automatic push(input string nm, input int d, input int st, input bit stp,
                      input int thr, input bit flt);
    exp_t e;
    e.due = cyc + d;
    e.st  = 3'(st);
    e.stp = stp;
    e.thr = 11'(thr);
    e.flt = flt;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // From DISARMED: request arm at zero throttle and ride through ARMING.
  task automatic arm_seq(input string tag);
    arm_req = 1'b1; stop_req = 1'b0; throttle_in = 11'd0;
    push({tag, "_arming"}, 1, 1, 1'b1, 0, 1'b0);
    push({tag, "_hold"},   4, 1, 1'b1, 0, 1'b0);
    push({tag, "_armed"},  5, 2, 1'b0, 0, 1'b0);
    tick(5);
  endtask

  // From STOPPED: drop both requests and acknowledge.
  task automatic clear_seq(input string tag);
    stop_req = 1'b0; arm_req = 1'b0; throttle_in = 11'd0;
    clear_req = 1'b1;
    push({tag, "_cleared"}, 1, 0, 1'b1, 0, 1'b0);
    tick(1);
    clear_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; arm_req = 1'b0; stop_req = 1'b0; heartbeat = 1'b0;
    clear_req = 1'b0; throttle_in = 11'd0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 1'b1, 0, 1'b0);
    tick(1);
    reset_n = 1'b1;
    push("idle", 1, 0, 1'b1, 0, 1'b0);
    tick(1);

    // Arm, then follow throttle with one cycle latency; clear_req ignored.
    arm_seq("arm1");
    throttle_in = 11'd500;
    push("thr500", 1, 2, 1'b0, 500, 1'b0);
    tick(1);
    clear_req = 1'b1;
    push("clear_in_armed", 1, 2, 1'b0, 500, 1'b0);
    tick(1);
    clear_req = 1'b0;

    // Soft stop ramp from 250: 150, 50, 0 every 2 cycles, then STOPPED.
    throttle_in = 11'd250;
    push("thr250", 1, 2, 1'b0, 250, 1'b0);
    tick(1);
    stop_req = 1'b1;
    push("ramp_entry", 1, 3, 1'b0, 250, 1'b0);
    push("ramp_150",   3, 3, 1'b0, 150, 1'b0);
    push("ramp_50",    5, 3, 1'b0, 50,  1'b0);
    push("ramp_0",     7, 3, 1'b0, 0,   1'b0);
    push("stopped",    8, 4, 1'b1, 0,   1'b0);
    tick(8);

    // Clear rules in STOPPED.
    arm_req = 1'b0; clear_req = 1'b1;
    push("clear_with_stop", 1, 4, 1'b1, 0, 1'b0);
    tick(1);
    clear_req = 1'b0;
    stop_req = 1'b0; arm_req = 1'b1; clear_req = 1'b1;
    push("clear_with_arm", 1, 4, 1'b1, 0, 1'b0);
    tick(1);
    clear_req = 1'b0;
    clear_seq("clr1");

    // Arm guards: nonzero throttle blocks arming; dropping arm aborts it.
    arm_req = 1'b1; throttle_in = 11'd300;
    push("guard_thr_a", 1, 0, 1'b1, 0, 1'b0);
    push("guard_thr_b", 3, 0, 1'b1, 0, 1'b0);
    tick(3);
    throttle_in = 11'd0;
    push("guard_arming", 1, 1, 1'b1, 0, 1'b0);
    push("guard_arming2", 3, 1, 1'b1, 0, 1'b0);
    tick(3);
    arm_req = 1'b0;
    push("guard_abort", 1, 0, 1'b1, 0, 1'b0);
    tick(1);

    // Ramp entered at zero throttle reaches STOPPED after one cycle.
    arm_seq("arm2");
    stop_req = 1'b1;
    push("zero_ramp", 1, 3, 1'b0, 0, 1'b0);
    push("zero_stopped", 2, 4, 1'b1, 0, 1'b0);
    tick(2);
    clear_seq("clr2");

    // Reset mid-ramp at throttle 150.
    arm_seq("arm3");
    throttle_in = 11'd250;
    push("r_thr250", 1, 2, 1'b0, 250, 1'b0);
    tick(1);
    stop_req = 1'b1;
    push("r_entry", 1, 3, 1'b0, 250, 1'b0);
    push("r_150",   3, 3, 1'b0, 150, 1'b0);
    tick(3);
    reset_n = 1'b0;
    push("reset_mid_ramp", 1, 0, 1'b1, 0, 1'b0);
    tick(1);
    reset_n = 1'b1; stop_req = 1'b0; arm_req = 1'b0; throttle_in = 11'd0;
    push("after_reset", 1, 0, 1'b1, 0, 1'b0);
    tick(1);

    // Reset while ARMED.
    arm_seq("arm4");
    throttle_in = 11'd500;
    push("a_thr500", 1, 2, 1'b0, 500, 1'b0);
    tick(1);
    reset_n = 1'b0;
    push("reset_armed", 1, 0, 1'b1, 0, 1'b0);
    tick(1);
    reset_n = 1'b1; arm_req = 1'b0; throttle_in = 11'd0;
    tick(1);

`ifdef MOTOR_STOP_WDT_EN
    // No heartbeat: 20 ARMED cycles then expiry into the ramp with fault set.
    arm_seq("wdt1");
    throttle_in = 11'd100;
    push("w_thr100",  1,  2, 1'b0, 100, 1'b0);
    push("w_last_ok", 19, 2, 1'b0, 100, 1'b0);
    push("w_expire",  20, 3, 1'b0, 100, 1'b1);
    push("w_ramp0",   22, 3, 1'b0, 0,   1'b1);
    push("w_stopped", 23, 4, 1'b1, 0,   1'b1);
    tick(23);
    clear_seq("wclr1");

    // Heartbeat every 15 cycles keeps it armed.
    arm_seq("wdt2");
    throttle_in = 11'd100;
    push("h_thr100", 1, 2, 1'b0, 100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(14);
      heartbeat = 1'b1;
      tick(1);
      heartbeat = 1'b0;
    end
    push("hb_kept", 0, 2, 1'b0, 100, 1'b0);
    // Heartbeat exactly in the expiry cycle wins.
    tick(19);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    push("hb_at_expiry", 0, 2, 1'b0, 100, 1'b0);
    push("hb_after_expiry", 5, 2, 1'b0, 100, 1'b0);
    tick(5);
    stop_req = 1'b1;
    push("h_entry",   1, 3, 1'b0, 100, 1'b0);
    push("h_ramp0",   3, 3, 1'b0, 0,   1'b0);
    push("h_stopped", 4, 4, 1'b1, 0,   1'b0);
    tick(4);
    clear_seq("wclr2");
`else
    // Without the watchdog, a long silent ARMED stretch stays armed.
    arm_seq("nowdt");
    throttle_in = 11'd100;
    push("n_thr100", 1, 2, 1'b0, 100, 1'b0);
    tick(5);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    tick(24);
    push("no_wdt_armed", 0, 2, 1'b0, 100, 1'b0);
    tick(1);
    stop_req = 1'b1;
    push("n_entry",   1, 3, 1'b0, 100, 1'b0);
    push("n_stopped", 4, 4, 1'b1, 0,   1'b0);
    tick(4);
    clear_seq("nclr");
`endif

    tick(3);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expected snapshots never compared, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + sb.size());
    $finish;
  end

endmodule
